register_file_mp: RTL and testbench
===================================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; depth = 2**ADDR_W entries.
REQ-003 Parameter NRD, default 4, number of read ports.
REQ-004 Parameter NWR, default 2, number of write ports; write port index also orders instructions (higher index = younger).
REQ-005 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding; 0 = reads return stored array contents only.
REQ-006 One clock and one reset; reset is asynchronous and active-high.
REQ-007 clk  in  1  rising-edge clock for all state.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 Rd_Addr  in  NRD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 Rd_Data  out  NRD*DATA_W  read data, same packing by port.
REQ-011 Rd_Busy  out  NRD  scoreboard busy flag of each read address.
REQ-012 Wr_En  in  NWR  write enables.
REQ-013 Wr_Addr  in  NWR*ADDR_W  write addresses.
REQ-014 Wr_Data  in  NWR*DATA_W  write data.
REQ-015 Set_En  in  NWR  issue-side enables; mark the destination as pending.
REQ-016 Set_Addr  in  NWR*ADDR_W  destinations to mark pending.
REQ-017 Busy_Count  out  ADDR_W+1  number of entries currently marked pending.

Function
REQ-018 Reads SHALL be combinational: for each port, address 0 -> data 0, busy 0.
REQ-019 Writes SHALL commit on the rising clk edge when Wr_En[k]=1 and Wr_Addr[k]!=0; writes to address 0 SHALL be discarded.
REQ-020 When several write ports target the same nonzero address in one cycle, the highest-index enabled port SHALL win; the others are dropped.
REQ-021 With BYPASS=1, a read whose address matches an enabled nonzero write in the same cycle SHALL return that write's data (highest-index match wins) and Rd_Busy=0 for that port.
REQ-022 With BYPASS=0, reads SHALL return pre-edge array contents; new data is visible the cycle after the write.
REQ-023 Scoreboard: one pending bit per entry; bit 0 is constant 0.
REQ-024 Set_En[k]=1 with nonzero Set_Addr[k] SHALL set the bit at the clock edge.
REQ-025 An enabled nonzero write SHALL clear the bit of its address at the clock edge.
REQ-026 Set and clear of the same address in the same cycle: set SHALL win (the new producer is younger than the completing one).
REQ-027 Rd_Busy[i] SHALL reflect the registered pending bit, except as overridden by REQ-018 and REQ-021.
REQ-028 Busy_Count SHALL be registered and equal the population count of the pending bits after each edge, range 0..2**ADDR_W-1.
REQ-029 Any read may equal any write or set address; no combination of simultaneous events SHALL produce X or corrupt other entries.

Reset
REQ-030 While reset=1, all entries SHALL read 0, all pending bits SHALL be 0, and Busy_Count SHALL be 0, independent of clk.
REQ-031 Reset asserted mid-cycle SHALL override any same-cycle write or set.
REQ-032 After deassertion, the first rising edge SHALL process writes and sets normally.

Verification
REQ-033 Reset, then write port0 r5=0x11111111 -> after the edge, all read ports at r5 return 0x11111111 and Rd_Busy=0.
REQ-034 Write port0 r7=0xAAAA0000 and port1 r7=0x0000BBBB in the same cycle -> r7 holds 0x0000BBBB; with BYPASS=1 a same-cycle read of r7 returns 0x0000BBBB.
REQ-035 Write r0=0xFFFFFFFF and Set r0 -> r0 reads 0, Rd_Busy=0, Busy_Count unchanged.
REQ-036 Set r3 and r9 -> Busy_Count=2 and Rd_Busy on r3 = 1; next cycle write r3 and Set r3 simultaneously -> r3 stays busy and Busy_Count stays 2.
REQ-037 Fill r1..r31 with data, set all pending, assert reset between clock edges -> all reads return 0 immediately, Busy_Count=0.
REQ-038 BYPASS=0 build: write r4=0x1234 -> the same-cycle read returns the old value; the next cycle returns 0x1234.

Source files
------------

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-ported register file with pending-bit scoreboard
//
// Purpose: 2**ADDR_W x DATA_W register file. It has NRD combinational read ports
// and NWR write ports. Each entry carries a pending bit that issue logic sets and
// that write-back clears. Register 0 is hardwired to zero and is never pending.
//
// Ports:
//   clk         rising-edge clock for all state
//   reset       asynchronous active-high reset (clears data, pending bits, count)
//   Rd_Addr     NRD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   Rd_Data     NRD packed read data, same packing
//   Rd_Busy     per-read-port pending flag
//   Wr_En       per-write-port enable
//   Wr_Addr     NWR packed write addresses
//   Wr_Data     NWR packed write data
//   Set_En      per-port issue enable (marks destination pending)
//   Set_Addr    NWR packed destinations to mark pending
//   Busy_Count  registered population count of the pending bits
module register_file_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 4,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NRD*ADDR_W-1:0]  Rd_Addr,
  output logic [NRD*DATA_W-1:0]  Rd_Data,
  output logic [NRD-1:0]         Rd_Busy,
  input  logic [NWR-1:0]         Wr_En,
  input  logic [NWR*ADDR_W-1:0]  Wr_Addr,
  input  logic [NWR*DATA_W-1:0]  Wr_Data,
  input  logic [NWR-1:0]         Set_En,
  input  logic [NWR*ADDR_W-1:0]  Set_Addr,
  output logic [ADDR_W:0]        Busy_Count
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending_q;
  logic [DEPTH-1:0]  pending_d;
  logic [ADDR_W:0]   count_d;
  logic [NWR-1:0]    wr_ok;   // enabled write to a nonzero register

  always_comb begin
    wr_ok = '0;
    for (int k = 0; k < NWR; k++) begin
      wr_ok[k] = Wr_En[k] && (Wr_Addr[k*ADDR_W +: ADDR_W] != '0);
    end
  end

  // Later ports are younger. Their non-blocking assignment is the last one in
  // the loop, so the highest enabled port wins a same-address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem[e] <= '0;
      end
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_ok[k]) begin
          mem[Wr_Addr[k*ADDR_W +: ADDR_W]] <= Wr_Data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Clears are applied before sets. When both hit the same entry, the set wins,
  // because the newly issued producer is younger than the one completing.
  always_comb begin
    pending_d = pending_q;
    for (int k = 0; k < NWR; k++) begin
      if (wr_ok[k]) begin
        pending_d[Wr_Addr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    for (int k = 0; k < NWR; k++) begin
      if (Set_En[k]) begin
        pending_d[Set_Addr[k*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    count_d = '0;
    for (int e = 0; e < DEPTH; e++) begin
      count_d = count_d + {{ADDR_W{1'b0}}, pending_d[e]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q  <= '0;
      Busy_Count <= '0;
    end else begin
      pending_q  <= pending_d;
      Busy_Count <= count_d;
    end
  end

  // The read path is gated by reset. A write presented while reset is high
  // must not leak through the bypass.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdata;
    logic              rbusy;
    Rd_Data = '0;
    Rd_Busy = '0;
    ra      = '0;
    rdata   = '0;
    rbusy   = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra    = Rd_Addr[i*ADDR_W +: ADDR_W];
      rdata = mem[ra];
      rbusy = pending_q[ra];
      if (BYPASS != 0) begin
        for (int k = 0; k < NWR; k++) begin
          if (wr_ok[k] && (Wr_Addr[k*ADDR_W +: ADDR_W] == ra)) begin
            rdata = Wr_Data[k*DATA_W +: DATA_W];
            rbusy = 1'b0;
          end
        end
      end
      if (reset || (ra == '0)) begin
        rdata = '0;
        rbusy = 1'b0;
      end
      Rd_Data[i*DATA_W +: DATA_W] = rdata;
      Rd_Busy[i]                  = rbusy;
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - self-checking bench for register_file_mp
module tb_register_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data, rd_data_nb;
  logic [NR-1:0]     rd_busy, rd_busy_nb;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic [NW-1:0]     set_en;
  logic [NW*AW-1:0]  set_addr;
  logic [AW:0]       busy_count, busy_count_nb;

  always #5 clk = ~clk;

  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW), .BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .Rd_Addr(rd_addr), .Rd_Data(rd_data), .Rd_Busy(rd_busy),
    .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
    .Set_En(set_en), .Set_Addr(set_addr), .Busy_Count(busy_count)
  );

  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset),
    .Rd_Addr(rd_addr), .Rd_Data(rd_data_nb), .Rd_Busy(rd_busy_nb),
    .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
    .Set_En(set_en), .Set_Addr(set_addr), .Busy_Count(busy_count_nb)
  );

  typedef struct {
    logic [1:0]   we;
    logic [9:0]   wa;    // {port1, port0}
    logic [63:0]  wd;
    logic [1:0]   se;
    logic [9:0]   sa;
    logic [19:0]  ra;    // {port3 .. port0}
    logic [127:0] ed;    // same-cycle read data on the bypassing instance
    logic [3:0]   eb;    // same-cycle busy flags
    logic [5:0]   ec;    // Busy_Count after the edge
  } vec_t;

  int passed = 0;
  int total  = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    set_en = '0; set_addr = '0;
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{we:2'b01, wa:{5'd0,5'd5}, wd:{32'h0,32'h11111111}, se:2'b00, sa:10'd0,
                 ra:{5'd5,5'd5,5'd5,5'd5}, ed:{4{32'h11111111}}, eb:4'b0000, ec:6'd0};
    vecs[1]  = '{we:2'b00, wa:10'd0, wd:64'd0, se:2'b00, sa:10'd0,
                 ra:{5'd5,5'd5,5'd5,5'd5}, ed:{4{32'h11111111}}, eb:4'b0000, ec:6'd0};
    vecs[2]  = '{we:2'b11, wa:{5'd7,5'd7}, wd:{32'h0000BBBB,32'hAAAA0000}, se:2'b00, sa:10'd0,
                 ra:{5'd0,5'd5,5'd7,5'd7}, ed:{32'h0,32'h11111111,32'h0000BBBB,32'h0000BBBB}, eb:4'b0000, ec:6'd0};
    vecs[3]  = '{we:2'b00, wa:10'd0, wd:64'd0, se:2'b00, sa:10'd0,
                 ra:{5'd7,5'd5,5'd0,5'd7}, ed:{32'h0000BBBB,32'h11111111,32'h0,32'h0000BBBB}, eb:4'b0000, ec:6'd0};
    vecs[4]  = '{we:2'b01, wa:{5'd0,5'd0}, wd:{32'h0,32'hFFFFFFFF}, se:2'b01, sa:{5'd0,5'd0},
                 ra:{5'd7,5'd0,5'd0,5'd0}, ed:{32'h0000BBBB,32'h0,32'h0,32'h0}, eb:4'b0000, ec:6'd0};
    vecs[5]  = '{we:2'b00, wa:10'd0, wd:64'd0, se:2'b11, sa:{5'd9,5'd3},
                 ra:{5'd5,5'd0,5'd9,5'd3}, ed:{32'h11111111,32'h0,32'h0,32'h0}, eb:4'b0000, ec:6'd2};
    vecs[6]  = '{we:2'b00, wa:10'd0, wd:64'd0, se:2'b00, sa:10'd0,
                 ra:{5'd5,5'd0,5'd9,5'd3}, ed:{32'h11111111,32'h0,32'h0,32'h0}, eb:4'b0011, ec:6'd2};
    vecs[7]  = '{we:2'b01, wa:{5'd0,5'd3}, wd:{32'h0,32'h33333333}, se:2'b10, sa:{5'd3,5'd0},
                 ra:{5'd1,5'd3,5'd9,5'd3}, ed:{32'h0,32'h33333333,32'h0,32'h33333333}, eb:4'b0010, ec:6'd2};
    vecs[8]  = '{we:2'b00, wa:10'd0, wd:64'd0, se:2'b00, sa:10'd0,
                 ra:{5'd1,5'd4,5'd9,5'd3}, ed:{32'h0,32'h0,32'h0,32'h33333333}, eb:4'b0011, ec:6'd2};
    vecs[9]  = '{we:2'b10, wa:{5'd9,5'd0}, wd:{32'h99,32'h0}, se:2'b00, sa:10'd0,
                 ra:{5'd0,5'd9,5'd3,5'd9}, ed:{32'h0,32'h99,32'h33333333,32'h99}, eb:4'b0010, ec:6'd1};
    vecs[10] = '{we:2'b10, wa:{5'd3,5'd0}, wd:{32'h44,32'h0}, se:2'b01, sa:{5'd0,5'd3},
                 ra:{5'd9,5'd9,5'd3,5'd3}, ed:{32'h99,32'h99,32'h44,32'h44}, eb:4'b0000, ec:6'd1};
    vecs[11] = '{we:2'b01, wa:{5'd0,5'd3}, wd:{32'h0,32'h55}, se:2'b00, sa:10'd0,
                 ra:{5'd9,5'd3,5'd9,5'd3}, ed:{32'h99,32'h55,32'h99,32'h55}, eb:4'b0000, ec:6'd0};
    vecs[12] = '{we:2'b00, wa:10'd0, wd:64'd0, se:2'b00, sa:10'd0,
                 ra:{5'd7,5'd5,5'd9,5'd3}, ed:{32'h0000BBBB,32'h11111111,32'h99,32'h55}, eb:4'b0000, ec:6'd0};
    vecs[13] = '{we:2'b01, wa:{5'd10,5'd10}, wd:{32'hB0B0,32'hA0A0}, se:2'b00, sa:10'd0,
                 ra:{5'd10,5'd10,5'd10,5'd10}, ed:{4{32'hA0A0}}, eb:4'b0000, ec:6'd0};
    vecs[14] = '{we:2'b00, wa:10'd0, wd:64'd0, se:2'b00, sa:10'd0,
                 ra:{5'd10,5'd10,5'd10,5'd10}, ed:{4{32'hA0A0}}, eb:4'b0000, ec:6'd0};

    // Reset state, including a write attempted while reset is held.
    reset = 1'b0;
    idle();
    rd_addr = {5'd0, 5'd3, 5'd4, 5'd5};
    #1 reset = 1'b1;
    #1;
    check("reset count", 64'(busy_count), 64'd0);
    check("reset rd5", 64'(rd_data[0 +: DW]), 64'd0);
    check("reset busy", 64'(rd_busy), 64'd0);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    set_en = 2'b01; set_addr = {5'd0, 5'd5};
    #1;
    check("reset bypass gated", 64'(rd_data[0 +: DW]), 64'd0);
    @(posedge clk); #1;
    check("reset write blocked", 64'(rd_data_nb[0 +: DW]), 64'd0);
    check("reset set blocked", 64'(busy_count), 64'd0);
    @(negedge clk);
    idle();
    reset = 1'b0;

    // Table-driven vectors. Busy_Count expectations go through the scoreboard.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      set_en = vecs[i].se; set_addr = vecs[i].sa; rd_addr = vecs[i].ra;
      exp_q.push_back(vecs[i].ec);
      #1;
      for (int p = 0; p < NR; p++) begin
        check($sformatf("v%0d rd%0d data", i, p), 64'(rd_data[p*DW +: DW]), 64'(vecs[i].ed[p*DW +: DW]));
      end
      check($sformatf("v%0d busy", i), 64'(rd_busy), 64'(vecs[i].eb));
      @(posedge clk); #1;
      begin
        logic [5:0] e;
        e = exp_q.pop_front();
        check($sformatf("v%0d count", i), 64'(busy_count), 64'(e));
        check($sformatf("v%0d count nb", i), 64'(busy_count_nb), 64'(e));
      end
    end

    // Non-bypassing instance: old value this cycle, new value next cycle.
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h1234};
    rd_addr = {5'd7, 5'd4, 5'd4, 5'd4};
    #1;
    check("nb r4 same cycle", 64'(rd_data_nb[0 +: DW]), 64'd0);
    check("bp r4 same cycle", 64'(rd_data[0 +: DW]), 64'h1234);
    check("nb r7 stored", 64'(rd_data_nb[3*DW +: DW]), 64'h0000BBBB);
    @(posedge clk); #1;
    idle();
    #1;
    check("nb r4 next cycle", 64'(rd_data_nb[0 +: DW]), 64'h1234);

    // Fill r1..r31 and mark every entry pending.
    for (int a = 1; a <= 31; a += 2) begin
      @(negedge clk);
      wr_en    = (a < 31) ? 2'b11 : 2'b01;
      wr_addr  = {5'(a + 1), 5'(a)};
      wr_data  = {32'((a + 1) * 32'h01010101), 32'(a * 32'h01010101)};
      set_en   = wr_en;
      set_addr = wr_addr;
    end
    @(negedge clk);
    idle();
    check("fill count", 64'(busy_count), 64'd31);
    for (int g = 0; g < 8; g++) begin
      if (g > 0) @(negedge clk);
      for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = 5'(g*4 + p);
      #1;
      for (int p = 0; p < NR; p++) begin
        check($sformatf("fill r%0d data", g*4 + p), 64'(rd_data[p*DW +: DW]), 64'(32'((g*4 + p) * 32'h01010101)));
      end
      check($sformatf("fill g%0d busy", g), 64'(rd_busy), (g == 0) ? 64'hE : 64'hF);
    end

    // Reset between edges, with a write and a set also being driven.
    @(negedge clk);
    wr_en = 2'b11; wr_addr = {5'd2, 5'd1}; wr_data = {32'hDEAD0002, 32'hDEAD0001};
    set_en = 2'b11; set_addr = {5'd2, 5'd1};
    rd_addr = {5'd31, 5'd5, 5'd2, 5'd1};
    #2 reset = 1'b1;
    #1;
    check("midreset data bp", 64'(rd_data), 64'd0);
    check("midreset data nb", 64'(rd_data_nb), 64'd0);
    check("midreset busy", 64'(rd_busy), 64'd0);
    check("midreset count", 64'(busy_count), 64'd0);
    @(posedge clk); #1;
    check("held reset count", 64'(busy_count), 64'd0);
    check("held reset data nb", 64'(rd_data_nb), 64'd0);

    // First edge after release processes writes and sets normally.
    @(negedge clk);
    reset = 1'b0;
    idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd2}; wr_data = {32'h0, 32'h22};
    set_en = 2'b10; set_addr = {5'd6, 5'd0};
    rd_addr = {5'd31, 5'd1, 5'd2, 5'd6};
    @(posedge clk); #1;
    idle();
    #1;
    check("post reset r6 busy", 64'(rd_busy), 64'h1);
    check("post reset r2", 64'(rd_data_nb[DW +: DW]), 64'h22);
    check("post reset r1", 64'(rd_data_nb[2*DW +: DW]), 64'd0);
    check("post reset r31", 64'(rd_data_nb[3*DW +: DW]), 64'd0);
    check("post reset count", 64'(busy_count), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
